// File: rtl/sram_banked.sv
// sram_banked: banked single-port SRAM buffer, read/write request channels with valid/ready.
// Latency: read accepted at edge T -> rsp_valid after edge T; write committed at the accepting edge.
// Backpressure: rd_ready drops while a response is held (rsp_valid && !rsp_ready); same-bank
//   conflicts go to the read until the write has stalled STARVE_MAX cycles, then the write wins.
// Ports: clk/rst_n (async active-low); wr_valid/wr_ready/wr_addr/wr_data/wr_be write channel;
//   rd_valid/rd_ready/rd_addr read channel; rsp_valid/rsp_ready/rsp_data/rsp_perr response;
//   perr_cnt saturating count of handed-off responses that carried a parity error.
// Option: SRAM_PARITY_EN adds even parity per byte and the test-only inj_perr input.
module sram_banked #(
  parameter int DEPTH      = 64,
  parameter int WIDTH      = 512,
  parameter int NUM_BANKS  = 4,
  parameter int STARVE_MAX = 4,
  parameter int ADDR_BITS  = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_perr,
  output logic [7:0]           perr_cnt
`ifdef SRAM_PARITY_EN
  ,
  input  logic                 inj_perr
`endif
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int ROWS      = DEPTH / NUM_BANKS;
  localparam int ROW_BITS  = ADDR_BITS - BANK_BITS;
  localparam int NBYTES    = WIDTH / 8;

  logic [BANK_BITS-1:0] rd_bank, wr_bank;
  logic [ROW_BITS-1:0]  rd_row, wr_row;

  assign rd_bank = rd_addr[BANK_BITS-1:0];
  assign wr_bank = wr_addr[BANK_BITS-1:0];
  assign rd_row  = rd_addr[ADDR_BITS-1:BANK_BITS];
  assign wr_row  = wr_addr[ADDR_BITS-1:BANK_BITS];

  logic [WIDTH-1:0] mem [NUM_BANKS][ROWS];

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]       starve_cnt_q, starve_cnt_d;

  logic rsp_out_free, conflict, wr_wins, rd_fire, wr_fire;

  // Arbitration. Readies are forced low in reset so nothing fires then.
  always_comb begin
    rsp_out_free = !rsp_valid_q || rsp_ready;
    conflict     = rd_valid && wr_valid && (rd_bank == wr_bank) && rsp_out_free;
    wr_wins      = conflict && (starve_cnt_q == 4'(STARVE_MAX));
    rd_ready     = rst_n && rsp_out_free && !wr_wins;
    wr_ready     = rst_n && (!conflict || wr_wins);
    rd_fire      = rd_valid && rd_ready;
    wr_fire      = wr_valid && wr_ready;
  end

  // A write that loses a conflict bumps the counter; any accepted write clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (wr_fire)       starve_cnt_d = '0;
    else if (conflict) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  // The response register is loaded only when a read is accepted, which requires the
  // slot to be free. It therefore doubles as the hold register: while a response is
  // stalled, later writes to the bank land in the array and cannot reach rsp_data.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (rd_fire) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = mem[rd_bank][rd_row];
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      starve_cnt_q <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be[i]) mem[wr_bank][wr_row][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef SRAM_PARITY_EN
  function automatic logic [NBYTES-1:0] byte_par(input logic [WIDTH-1:0] d);
    logic [NBYTES-1:0] p;
    for (int i = 0; i < NBYTES; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  logic [NBYTES-1:0] par [NUM_BANKS][ROWS];
  logic [NBYTES-1:0] wr_par;
  logic              rsp_perr_q, rsp_perr_d;
  logic [7:0]        perr_cnt_q, perr_cnt_d;

  // inj_perr inverts every parity bit written, so any enabled byte reads back bad.
  assign wr_par = byte_par(wr_data) ^ {NBYTES{inj_perr}};

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be[i]) par[wr_bank][wr_row][i] <= wr_par[i];
      end
    end
  end

  always_comb begin
    rsp_perr_d = rsp_perr_q;
    if (rd_fire) rsp_perr_d = |(byte_par(mem[rd_bank][rd_row]) ^ par[rd_bank][rd_row]);
    perr_cnt_d = perr_cnt_q;
    if (rsp_valid_q && rsp_ready && rsp_perr_q && (perr_cnt_q != 8'hFF))
      perr_cnt_d = perr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_perr_q <= 1'b0;
      perr_cnt_q <= '0;
    end else begin
      rsp_perr_q <= rsp_perr_d;
      perr_cnt_q <= perr_cnt_d;
    end
  end

  assign rsp_perr = rsp_perr_q;
  assign perr_cnt = perr_cnt_q;
`else
  assign rsp_perr = 1'b0;
  assign perr_cnt = 8'd0;
`endif

endmodule

// File: doc/sram_banked.md
# sram_banked

Banked single-port SRAM with independent read and write request channels, valid/ready handshakes, per-byte write enables and a held read-response channel. Low-order address interleaving gives up to one read and one write per cycle when they target different banks. Same-bank conflicts are arbitrated with read priority, bounded by a write-starvation counter. It sits between the DMA/load path (writes) and the systolic array operand fetch (reads), as the unified activation/weight buffer.

## Interface
- `DEPTH`, 64: total words; must be a multiple of `NUM_BANKS`.
- `WIDTH`, 512: word width in bits; must be a multiple of 8.
- `NUM_BANKS`, 4: bank count; power of two, ≥ 2.
- `STARVE_MAX`, 4: consecutive conflict-stalled write cycles before the write wins; range 1..15.
- `ADDR_BITS`, `$clog2(DEPTH)`: address width (derived).
- `clk` in 1: the only clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_valid` in 1: write request present.
- `wr_ready` out 1: write accepted this cycle when high with `wr_valid`.
- `wr_addr` in `ADDR_BITS`: write word address.
- `wr_data` in `WIDTH`: write data.
- `wr_be` in `WIDTH/8`: byte enables; bit i covers bits [8i+7:8i].
- `rd_valid` in 1: read request present.
- `rd_ready` out 1: read accepted this cycle when high with `rd_valid`.
- `rd_addr` in `ADDR_BITS`: read word address.
- `rsp_valid` out 1: read data available.
- `rsp_ready` in 1: consumer takes response.
- `rsp_data` out `WIDTH`: read data.
- `rsp_perr` out 1: parity error flag for the current response.
- `perr_cnt` out 8: saturating count of responses with a parity error.

## Operation
- Bank = `addr[log2(NUM_BANKS)-1:0]`; row = `addr >> log2(NUM_BANKS)`. Each bank holds `DEPTH/NUM_BANKS` rows. Each bank is single-port, with synchronous read and byte-masked synchronous write.
- Read slot free: `rsp_out_free = !rsp_valid || rsp_ready`.
- Conflict: `rd_valid && wr_valid && rd_bank == wr_bank && rsp_out_free`.
- With no conflict:
  - `rd_ready = rsp_out_free`.
  - `wr_ready = 1`.
  - Both requests may fire in the same cycle.
- With a conflict:
  - Normally the read wins: `rd_ready=1`, `wr_ready=0`, and `starve_cnt` increments.
  - When `starve_cnt == STARVE_MAX`, the write wins instead: `wr_ready=1`, `rd_ready=0`.
- `starve_cnt` clears on any accepted write. It holds when `wr_valid` is low.
- A write with `wr_be == 0` is accepted and changes no memory.
- Response path:
  - An accepted read produces `rsp_valid` on the next cycle.
  - `rsp_data` and `rsp_perr` remain stable while `rsp_valid && !rsp_ready`.
  - A hold register captures the bank output on the first unaccepted cycle. Later writes to that bank must not disturb the held response.
- Read and write to different addresses in the same cycle are independent.
- Memory contents are not reset. Simulation initialises all rows to zero, which is consistent with `SRAM_PARITY_EN` parity.
- `perr_cnt` increments once per response that is handed off (`rsp_valid && rsp_ready && rsp_perr`). It saturates at 255.

## Timing
- Reset values: `wr_ready=0` and `rd_ready=0` while `rst_n` is low; `rsp_valid=0`, `rsp_data=0`, `rsp_perr=0`, `perr_cnt=0`, `starve_cnt=0`.
- Reset asserted mid-operation drops any pending response. A write that completes its edge before reset is retained in memory.
- Read latency: request accepted at edge T, `rsp_valid` high after edge T.
- Throughput is one read per cycle with `rsp_ready` held high.
- Write is committed at the accepting edge. A read accepted on a later edge sees the new data.
- `wr_ready` and `rd_ready` are combinational from the valids, addresses, `rsp_valid`, `rsp_ready` and state. The valids must not depend on the readies.

## Configuration
- `SRAM_PARITY_EN` defined:
  - Each bank stores `WIDTH/8` extra bits: even parity per byte, written with the byte under `wr_be`.
  - On read, parity is recomputed. `rsp_perr` is high if any byte mismatches.
  - A test-only port `inj_perr` (in, 1) flips stored parity on writes accepted while it is high.
- `SRAM_PARITY_EN` undefined:
  - No parity storage.
  - `rsp_perr` is tied to 0 and `perr_cnt` to 0.
  - The `inj_perr` port is absent.

## Test plan
- Reset, then write 0xA5 repeated to addr 5 with all bytes enabled, then read addr 5 → after one cycle `rsp_valid=1`, `rsp_data` is all 0xA5.
- Write all-FF to addr 9, then write 0x00 to addr 9 with `wr_be` = 0x1 only, then read addr 9 → byte0 = 0x00, other bytes 0xFF.
- Hold `rd_valid` and `wr_valid` continuously, both targeting bank 1 (addrs 1 and 5), with `STARVE_MAX`=4 → 4 reads accepted, then 1 write, repeating.
- Concurrent read of addr 2 and write of addr 3 → both accepted in the same cycle.
- Response backpressure: hold `rsp_ready=0` for 3 cycles after a read of addr 4, and write addr 8 (same bank) meanwhile → `rsp_data` unchanged and `rd_ready=0` throughout; data is consumed when `rsp_ready` rises.
- With `SRAM_PARITY_EN`: write addr 7 with `inj_perr=1`, then read it twice → `rsp_perr=1` on both, `perr_cnt=2`. Assert reset mid-response → all outputs return to reset values.
